// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with two registered read ports,
// one write port, write-first bypass, optional hardwired zero entry and a
// reset-driven clear sequencer that zeroes every entry before use.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] Reg1,
  input  logic [ADDR_W-1:0] Reg2,
  input  logic              RE,
  output logic [DATA_W-1:0] Reg1_data,
  output logic [DATA_W-1:0] Reg2_data,
  input  logic [ADDR_W-1:0] Write_Reg,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              WE,
  output logic              Busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;
  logic                wr_ok;

  // Write to entry 0 is dropped when it is hardwired to zero.
  assign wr_ok = WE && !((ZERO_REG != 0) && (Write_Reg == '0));

  // Read value for one port: zero entry wins, then the same-cycle write,
  // then the stored entry.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              byp_en,
    input logic [ADDR_W-1:0] byp_addr,
    input logic [DATA_W-1:0] byp_data,
    input logic [DATA_W-1:0] stored
  );
    if ((ZERO_REG != 0) && (addr == '0)) begin
      return '0;
    end else if (byp_en && (byp_addr == addr)) begin
      return byp_data;
    end else begin
      return stored;
    end
  endfunction

  // Next-state logic: clear sequencing, write-port steering and read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    mem_we  = 1'b0;
    mem_wa  = Write_Reg;
    mem_wd  = Write_Data;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + ADDR_W'(1);
        rd1_d  = '0;
        rd2_d  = '0;
        if (cnt_q == LAST_IDX) begin
          state_d = READY;
        end
      end
      READY: begin
        mem_we = wr_ok;
        if (RE) begin
          rd1_d = read_port(Reg1, wr_ok, Write_Reg, Write_Data, mem_q[Reg1]);
          rd2_d = read_port(Reg2, wr_ok, Write_Reg, Write_Data, mem_q[Reg2]);
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and read-output registers; reset restarts the clear sequence.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  // Storage array; any write coinciding with a reset edge is discarded.
  always_ff @(posedge CLK) begin
    if (RST_N && mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign Reg1_data = rd1_q;
  assign Reg2_data = rd2_q;
  assign Busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_file_param.sv
// Testbench for reg_file_param: two instances (zero register on / off) driven
// with identical stimulus; expected read data goes through a scoreboard queue.
module tb_reg_file_param;

  logic        CLK;
  logic        RST_N;
  logic [4:0]  Reg1, Reg2, Write_Reg;
  logic        RE, WE;
  logic [31:0] Write_Data;
  logic [31:0] a_r1, a_r2, b_r1, b_r2;
  logic        a_busy, b_busy;

  int nchk  = 0;
  int nfail = 0;

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] b1;
    logic [31:0] b2;
    string       nm;
  } exp_t;

  exp_t sb[$];

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .Reg1(Reg1), .Reg2(Reg2), .RE(RE),
    .Reg1_data(a_r1), .Reg2_data(a_r2), .Write_Reg(Write_Reg),
    .Write_Data(Write_Data), .WE(WE), .Busy(a_busy)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .Reg1(Reg1), .Reg2(Reg2), .RE(RE),
    .Reg1_data(b_r1), .Reg2_data(b_r2), .Write_Reg(Write_Reg),
    .Write_Data(Write_Data), .WE(WE), .Busy(b_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pop one expected entry and compare both instances' outputs.
  task automatic pop_check();
    exp_t e;
    nchk++;
    if (sb.size() == 0) begin
      nfail++;
      $display("FAIL scoreboard_empty: got 0 entries, required at least 1");
      return;
    end
    e = sb.pop_front();
    if (a_r1 !== e.a1) begin
      nfail++;
      $display("FAIL %s zr1.Reg1_data: got %h, required %h", e.nm, a_r1, e.a1);
    end
    nchk++;
    if (a_r2 !== e.a2) begin
      nfail++;
      $display("FAIL %s zr1.Reg2_data: got %h, required %h", e.nm, a_r2, e.a2);
    end
    nchk++;
    if (b_r1 !== e.b1) begin
      nfail++;
      $display("FAIL %s zr0.Reg1_data: got %h, required %h", e.nm, b_r1, e.b1);
    end
    nchk++;
    if (b_r2 !== e.b2) begin
      nfail++;
      $display("FAIL %s zr0.Reg2_data: got %h, required %h", e.nm, b_r2, e.b2);
    end
  endtask

  // One clock cycle of stimulus; when chk is set the expected outputs are
  // queued with the stimulus and compared just after the edge.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic re, input logic [4:0] r1, input logic [4:0] r2,
                     input bit chk, input logic [31:0] a1, input logic [31:0] a2,
                     input logic [31:0] b1, input logic [31:0] b2, input string nm);
    @(negedge CLK);
    WE = we; Write_Reg = wa; Write_Data = wd;
    RE = re; Reg1 = r1; Reg2 = r2;
    if (chk) sb.push_back('{a1: a1, a2: a2, b1: b1, b2: b2, nm: nm});
    @(posedge CLK);
    #1;
    WE = 1'b0; RE = 1'b0;
    if (chk) pop_check();
  endtask

  // Release reset and count edges until Busy drops; expect the full depth.
  task automatic release_and_count(input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      #1;
      n++;
      if (!a_busy) break;
    end
    nchk++;
    if (n != 32 || a_busy !== 1'b0) begin
      nfail++;
      $display("FAIL %s busy_cycles: got %0d (busy=%b), required 32 (busy=0)", nm, n, a_busy);
    end
    nchk++;
    if (b_busy !== 1'b0) begin
      nfail++;
      $display("FAIL %s zr0.busy_after_clear: got %b, required 0", nm, b_busy);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST_N = 1'b0; WE = 1'b0; RE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nchk++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
      nfail++;
      $display("FAIL reset_busy: got %b/%b, required 1/1", a_busy, b_busy);
    end
    nchk++;
    if (a_r1 !== 32'h0 || a_r2 !== 32'h0 || b_r1 !== 32'h0 || b_r2 !== 32'h0) begin
      nfail++;
      $display("FAIL reset_outputs: got %h %h %h %h, required all 0", a_r1, a_r2, b_r1, b_r2);
    end
    release_and_count("reset_clear");
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i), 1'b1,
          32'h0, 32'h0, 32'h0, 32'h0, "clear_read");
    end
  endtask

  task automatic test_write_read();
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, '0, '0, '0, '0, "");
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 1'b1,
        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, "write_read");
  endtask

  task automatic test_bypass();
    cyc(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0, 1'b0, '0, '0, '0, '0, "");
    cyc(1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 5'd0, 1'b0, '0, '0, '0, '0, "");
    cyc(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd3, 1'b1,
        32'h22222222, 32'h00000033, 32'h22222222, 32'h00000033, "bypass");
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 1'b1,
        32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222, "after_bypass");
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 5'd12, 32'hCAFEF00D, 1'b1, 5'd12, 5'd5, 1'b1,
        32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, "b2b_0");
    cyc(1'b1, 5'd13, 32'h12345678, 1'b1, 5'd12, 5'd13, 1'b1,
        32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 32'h12345678, "b2b_1");
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd3, 1'b1,
        32'h12345678, 32'h00000033, 32'h12345678, 32'h00000033, "b2b_2");
  endtask

  task automatic test_zero_reg();
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd5, 1'b1,
        32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, "zero_bypass");
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b1,
        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, "zero_later");
  endtask

  task automatic test_re_hold();
    cyc(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 1'b0, '0, '0, '0, '0, "");
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 1'b1,
        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, "hold_pre");
    cyc(1'b1, 5'd9, 32'h5A5A5A5A, 1'b0, 5'd10, 5'd10, 1'b1,
        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, "hold_re0");
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd9, 1'b1,
        32'h0, 32'h5A5A5A5A, 32'h0, 32'h5A5A5A5A, "hold_re1");
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 5'd4, 32'h00000044, 1'b0, 5'd0, 5'd0, 1'b0, '0, '0, '0, '0, "");
    // reset on the same edge as a write to entry 4
    @(negedge CLK);
    RST_N = 1'b0; WE = 1'b1; Write_Reg = 5'd4; Write_Data = 32'h99999999;
    RE = 1'b1; Reg1 = 5'd4; Reg2 = 5'd4;
    sb.push_back('{a1: 32'h0, a2: 32'h0, b1: 32'h0, b2: 32'h0, nm: "reset_with_write"});
    @(posedge CLK);
    #1;
    WE = 1'b0; RE = 1'b0;
    pop_check();
    nchk++;
    if (a_busy !== 1'b1) begin
      nfail++;
      $display("FAIL reset_with_write_busy: got %b, required 1", a_busy);
    end
    // release, then reset again at clear count 12
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    nchk++;
    if (a_busy !== 1'b1) begin
      nfail++;
      $display("FAIL mid_clear_busy_before: got %b, required 1", a_busy);
    end
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    nchk++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
      nfail++;
      $display("FAIL mid_clear_busy_in_reset: got %b/%b, required 1/1", a_busy, b_busy);
    end
    release_and_count("mid_clear_restart");
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd5, 1'b1,
        32'h0, 32'h0, 32'h0, 32'h0, "after_mid_reset");
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd31, 1'b1,
        32'h0, 32'h0, 32'h0, 32'h0, "after_mid_reset_2");
  endtask

  initial begin
    RST_N = 1'b0; WE = 1'b0; RE = 1'b0;
    Reg1 = '0; Reg2 = '0; Write_Reg = '0; Write_Data = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_zero_reg();
    test_re_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
